// File: rtl/dcache_pkg.sv
// Shared constants for the data cache: FSM encodings, default geometry and tag sizing.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dcache_pkg;

    localparam int LINES = 16;
    localparam int OFF_W = 3;
    localparam int IDX_W = $clog2(LINES);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] REFILL = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;
    localparam logic [1:0] WR_MEM = 2'd3;

    function automatic int tagWidth(input int addrW, input int offW);
        return addrW - offW;
    endfunction

endpackage

// File: rtl/dcache_if.sv
// Pipeline-side and memory-side bundles of the data cache controller.
// Latency: n/a (wiring only).
// Backpressure: stall on the pipeline side, level req held until one-cycle ack on the memory side.
interface dcache_cpu_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              MemRead;
    logic              MemWrite;
    logic [ADDR_W-1:0] ALU_Result;
    logic [DATA_W-1:0] Read_data2;
    logic [DATA_W-1:0] Read_data;
    logic              stall;

    modport master (output MemRead, MemWrite, ALU_Result, Read_data2,
                    input  Read_data, stall);
    modport slave  (input  MemRead, MemWrite, ALU_Result, Read_data2,
                    output Read_data, stall);
endinterface

interface dcache_mem_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                    input  mem_ack, mem_rdata);
    modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                    output mem_ack, mem_rdata);
endinterface

// File: rtl/dcache_victim_sel.sv
// Picks the refill victim: lowest-index invalid line, else the round-robin pointer.
// Latency: combinational.
// Backpressure: none.
module dcache_victim_sel
    import dcache_pkg::*;
#(
    parameter int LINES = dcache_pkg::LINES,
    parameter int IW    = $clog2(LINES)
) (
    input  logic [LINES-1:0] lineValid,
    input  logic [IW-1:0]    rrPtr,
    output logic [IW-1:0]    victim,
    output logic             victimValid
);

    // Descending scan so the lowest free index is the last one written.
    always_comb begin
        victim      = rrPtr;
        victimValid = 1'b1;
        for (int i = LINES - 1; i >= 0; i--) begin
            if (!lineValid[i]) begin
                victim      = IW'(i);
                victimValid = 1'b0;
            end
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Fully associative, write-through, no-write-allocate data cache with miss refill FSM.
// Latency: load hit 0 cycles; load miss stalls until ack, data in the following cycle; store stalls until ack.
// Backpressure: stall to the pipeline; optional hit/miss counters under DCACHE_PERF_CNT_EN.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int LINES  = dcache_pkg::LINES,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int OFF_W  = dcache_pkg::OFF_W
) (
    input  logic         clk,
    input  logic         reset_n,
    dcache_cpu_if.slave  cpu,
    dcache_mem_if.master mem
`ifdef DCACHE_PERF_CNT_EN
    ,
    output logic [31:0]  hit_count,
    output logic [31:0]  miss_count
`endif
);

    localparam int IW = $clog2(LINES);
    localparam int TW = tagWidth(ADDR_W, OFF_W);

    logic [1:0]        state;
    logic [LINES-1:0]  lineValid;
    logic [TW-1:0]     lineTag  [LINES];
    logic [DATA_W-1:0] lineData [LINES];
    logic [IW-1:0]     rrPtr;

    logic              memReqQ;
    logic              memWeQ;
    logic [ADDR_W-1:0] memAddrQ;
    logic [DATA_W-1:0] memWdataQ;
    logic [DATA_W-1:0] rdQ;

    logic [TW-1:0]     reqTag;
    logic              isLoad;
    logic              isStore;
    logic              hit;
    logic [IW-1:0]     hitIdx;
    logic [IW-1:0]     victim;
    logic              victimValid;
    logic              stallC;
    logic              unusedOffBits;

    assign reqTag        = cpu.ALU_Result[ADDR_W-1:OFF_W];
    assign unusedOffBits = ^cpu.ALU_Result[OFF_W-1:0];
    // A combined read/write request behaves as a plain load.
    assign isLoad        = cpu.MemRead;
    assign isStore       = cpu.MemWrite & ~cpu.MemRead;

    always_comb begin
        hit    = 1'b0;
        hitIdx = '0;
        for (int i = 0; i < LINES; i++) begin
            if (lineValid[i] && (lineTag[i] == reqTag)) begin
                hit    = 1'b1;
                hitIdx = IW'(i);
            end
        end
    end

    dcache_victim_sel #(
        .LINES (LINES),
        .IW    (IW)
    ) u_victim_sel (
        .lineValid   (lineValid),
        .rrPtr       (rrPtr),
        .victim      (victim),
        .victimValid (victimValid)
    );

    always_comb begin
        stallC = 1'b0;
        case (state)
            IDLE:    stallC = (isLoad & ~hit) | isStore;
            REFILL:  stallC = 1'b1;
            WR_MEM:  stallC = ~mem.mem_ack;
            default: stallC = 1'b0;
        endcase
    end

    // Reset must release the pipeline at once even if a request is still presented.
    assign cpu.stall     = stallC & reset_n;
    assign cpu.Read_data = ((state == IDLE) && isLoad && hit) ? lineData[hitIdx] : rdQ;

    assign mem.mem_req   = memReqQ & ~((state == WR_MEM) & mem.mem_ack);
    assign mem.mem_we    = memWeQ;
    assign mem.mem_addr  = memAddrQ;
    assign mem.mem_wdata = memWdataQ;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            lineValid <= '0;
            rrPtr     <= '0;
            memReqQ   <= 1'b0;
            memWeQ    <= 1'b0;
            memAddrQ  <= '0;
            memWdataQ <= '0;
            rdQ       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (isLoad) begin
                        if (hit) begin
                            rdQ <= lineData[hitIdx];
                        end else begin
                            memAddrQ <= {reqTag, {OFF_W{1'b0}}};
                            memReqQ  <= 1'b1;
                            memWeQ   <= 1'b0;
                            state    <= REFILL;
                        end
                    end else if (isStore) begin
                        memAddrQ  <= {reqTag, {OFF_W{1'b0}}};
                        memWdataQ <= cpu.Read_data2;
                        memReqQ   <= 1'b1;
                        memWeQ    <= 1'b1;
                        state     <= WR_MEM;
                    end
                end
                REFILL: begin
                    if (mem.mem_ack) begin
                        memReqQ           <= 1'b0;
                        rdQ               <= mem.mem_rdata;
                        lineValid[victim] <= 1'b1;
                        // Filling an empty line leaves the replacement order untouched.
                        if (victimValid) begin
                            rrPtr <= rrPtr + 1'b1;
                        end
                        state <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                WR_MEM: begin
                    if (mem.mem_ack) begin
                        memReqQ <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Tag/data payload needs no reset; lineValid qualifies every use.
    always_ff @(posedge clk) begin
        if ((state == IDLE) && isStore && hit) begin
            lineData[hitIdx] <= cpu.Read_data2;
        end else if ((state == REFILL) && mem.mem_ack) begin
            lineData[victim] <= mem.mem_rdata;
            lineTag[victim]  <= memAddrQ[ADDR_W-1:OFF_W];
        end
    end

`ifdef DCACHE_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if ((state == IDLE) && isLoad) begin
            if (hit) begin
                if (hit_count != 32'hFFFF_FFFF) begin
                    hit_count <= hit_count + 32'd1;
                end
            end else if (miss_count != 32'hFFFF_FFFF) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboarded bench for dcache_ctrl: directed loads/stores against a latency-programmable memory model.
module tb_dcache_ctrl;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    dcache_cpu_if #(.ADDR_W(32), .DATA_W(32)) cpu ();
    dcache_mem_if #(.ADDR_W(32), .DATA_W(32)) mem ();

`ifdef DCACHE_PERF_CNT_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    dcache_ctrl #(
        .LINES  (16),
        .ADDR_W (32),
        .DATA_W (32),
        .OFF_W  (3)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cpu        (cpu),
        .mem        (mem)
`ifdef DCACHE_PERF_CNT_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } memTxn_t;

    int checks   = 0;
    int failures = 0;
    int ackLat   = 1;
    int reqCnt   = 0;
    int expHit   = 0;
    int expMiss  = 0;

    logic [31:0] rdExpQ [$];
    memTxn_t     memExpQ [$];
    logic [31:0] memArr [logic [31:0]];
    logic [31:0] monExp;
    memTxn_t     monTxn;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    function automatic memTxn_t mkTxn(input logic we, input logic [31:0] a, input logic [31:0] d);
        memTxn_t t;
        t.we    = we;
        t.addr  = a & 32'hFFFF_FFF8;
        t.wdata = d;
        return t;
    endfunction

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    // Memory model: acks after ackLat cycles of mem_req, one-cycle ack pulse.
    initial begin
        mem.mem_ack   = 1'b0;
        mem.mem_rdata = '0;
    end

    always @(negedge clk) begin
        if (!reset_n || mem.mem_ack) begin
            mem.mem_ack = 1'b0;
            reqCnt      = 0;
        end else if (mem.mem_req) begin
            reqCnt++;
            if (reqCnt >= ackLat) begin
                mem.mem_ack = 1'b1;
                if (mem.mem_we)
                    memArr[mem.mem_addr] = mem.mem_wdata;
                else
                    mem.mem_rdata = memArr.exists(mem.mem_addr) ? memArr[mem.mem_addr] : dflt(mem.mem_addr);
            end
        end
    end

    // Monitor: retiring loads and memory transactions are popped against the scoreboard.
    always @(negedge clk) begin
        #2;
        if (reset_n && cpu.MemRead && !cpu.stall) begin
            if (rdExpQ.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL load_unexpected actual=0x%08h expected=none", cpu.Read_data);
            end else begin
                monExp = rdExpQ.pop_front();
                check("load_data", cpu.Read_data, monExp);
            end
        end
        if (mem.mem_ack) begin
            if (memExpQ.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL mem_unexpected actual_addr=0x%08h actual_we=%0b expected=none", mem.mem_addr, mem.mem_we);
            end else begin
                monTxn = memExpQ.pop_front();
                check("mem_we", {31'd0, mem.mem_we}, {31'd0, monTxn.we});
                check("mem_addr", mem.mem_addr, monTxn.addr);
                if (monTxn.we)
                    check("mem_wdata", mem.mem_wdata, monTxn.wdata);
            end
        end
    end

    task automatic doOp(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input int expStall, input string name);
        int n = 0;
        cpu.MemRead    = rd;
        cpu.MemWrite   = wr;
        cpu.ALU_Result = addr;
        cpu.Read_data2 = wdata;
        #1;
        while (cpu.stall && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({name, "_stall_cycles"}, 32'(n), 32'(expStall));
        @(negedge clk);
        cpu.MemRead  = 1'b0;
        cpu.MemWrite = 1'b0;
    endtask

    task automatic loadOp(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                          input logic [31:0] expData, input logic miss, input string name);
        rdExpQ.push_back(expData);
        if (miss) begin
            memExpQ.push_back(mkTxn(1'b0, addr, 32'd0));
            expMiss++;
        end else begin
            expHit++;
        end
        doOp(1'b1, wr, addr, wdata, miss ? ackLat + 1 : 0, name);
    endtask

    task automatic load(input logic [31:0] addr, input logic [31:0] expData, input logic miss, input string name);
        loadOp(addr, 1'b0, 32'd0, expData, miss, name);
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data, input string name);
        memExpQ.push_back(mkTxn(1'b1, addr, data));
        doOp(1'b0, 1'b1, addr, data, ackLat, name);
    endtask

    task automatic doReset();
        cpu.MemRead  = 1'b0;
        cpu.MemWrite = 1'b0;
        reset_n      = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        expHit  = 0;
        expMiss = 0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cpu.MemRead    = 1'b0;
        cpu.MemWrite   = 1'b0;
        cpu.ALU_Result = '0;
        cpu.Read_data2 = '0;
        memArr[32'h28] = 32'hDEADBEEF;

        @(negedge clk);
        #1;
        check("rst_read_data", cpu.Read_data, 32'd0);
        check("rst_stall", {31'd0, cpu.stall}, 32'd0);
        check("rst_mem_req", {31'd0, mem.mem_req}, 32'd0);
        check("rst_mem_we", {31'd0, mem.mem_we}, 32'd0);
        check("rst_mem_addr", mem.mem_addr, 32'd0);
        check("rst_mem_wdata", mem.mem_wdata, 32'd0);
`ifdef DCACHE_PERF_CNT_EN
        check("rst_hit_count", hit_count, 32'd0);
        check("rst_miss_count", miss_count, 32'd0);
`endif
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Refill, then a hit on the same tag at a different offset.
        ackLat = 1;
        load(32'h28, 32'hDEADBEEF, 1'b1, "t1_miss");
        load(32'h2C, 32'hDEADBEEF, 1'b0, "t1_hit");

        // Write-through on a hit updates the line.
        store(32'h28, 32'h12345678, "t2_store");
        load(32'h28, 32'h12345678, 1'b0, "t2_hit");

        // Store miss does not allocate.
        store(32'h100, 32'h0BADF00D, "t3_store");
        load(32'h100, 32'h0BADF00D, 1'b1, "t3_miss");

        // Replacement: fill all lines, evict line 0, then wrap the pointer.
        doReset();
        for (int i = 0; i < 16; i++)
            load(32'h1000 + 32'(i * 8), dflt(32'h1000 + 32'(i * 8)), 1'b1, "t4_fill");
        load(32'h1080, dflt(32'h1080), 1'b1, "t4_evict0");
        load(32'h1000, dflt(32'h1000), 1'b1, "t4_first_gone");
        load(32'h1080, dflt(32'h1080), 1'b0, "t4_17th_hit");
        load(32'h1010, dflt(32'h1010), 1'b0, "t4_line2_hit");
        for (int j = 0; j < 16; j++)
            load(32'h2000 + 32'(j * 8), dflt(32'h2000 + 32'(j * 8)), 1'b1, "t4_more");
        load(32'h3000, dflt(32'h3000), 1'b1, "t4_after_wrap");
        load(32'h2008, dflt(32'h2008), 1'b0, "t4_u1_hit");
        load(32'h2070, dflt(32'h2070), 1'b0, "t4_u14_hit");
        load(32'h2078, dflt(32'h2078), 1'b0, "t4_u15_hit");
        load(32'h2000, dflt(32'h2000), 1'b1, "t4_u0_gone");

        // Reset during an outstanding refill.
        load(32'h28, 32'h12345678, 1'b1, "t5_prime");
        ackLat         = 20;
        cpu.MemRead    = 1'b1;
        cpu.ALU_Result = 32'h300;
        repeat (3) @(negedge clk);
        #1;
        check("t5_pre_stall", {31'd0, cpu.stall}, 32'd1);
        check("t5_pre_req", {31'd0, mem.mem_req}, 32'd1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("t5_rst_req", {31'd0, mem.mem_req}, 32'd0);
        check("t5_rst_stall", {31'd0, cpu.stall}, 32'd0);
        check("t5_rst_addr", mem.mem_addr, 32'd0);
        check("t5_rst_rdata", cpu.Read_data, 32'd0);
        cpu.MemRead = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        ackLat  = 1;
        expHit  = 0;
        expMiss = 0;
        @(negedge clk);
        load(32'h28, 32'h12345678, 1'b1, "t5_reload_miss");

        // Combined read/write acts as a load only.
        loadOp(32'h28, 1'b1, 32'hFFFF0000, 32'h12345678, 1'b0, "t6_rw_hit");
        load(32'h28, 32'h12345678, 1'b0, "t6_unchanged");
        ackLat = 5;
        loadOp(32'h400, 1'b1, 32'hFFFF0000, dflt(32'h400), 1'b1, "t6_rw_miss");
        ackLat = 1;
`ifdef DCACHE_PERF_CNT_EN
        check("t6_hit_count", hit_count, 32'(expHit));
        check("t6_miss_count", miss_count, 32'(expMiss));
`endif

        repeat (3) @(negedge clk);
        check("rd_queue_drained", 32'(rdExpQ.size()), 32'd0);
        check("mem_queue_drained", 32'(memExpQ.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
